// File: rtl/ascii_dec_parser_pkg.sv
// Shared constants, parser state encoding and byte classification for the
// ASCII decimal parser.
package ascii_dec_parser_pkg;

   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_MINUS = 8'h2D;
   localparam logic [7:0] CHAR_ZERO  = 8'h30;

   localparam int DEFAULT_WIDTH      = 32;
   localparam int DEFAULT_MAX_DIGITS = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SKIP  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      CLS_DIGIT,
      CLS_TERM,
      CLS_SPACE,
      CLS_MINUS,
      CLS_ILLEGAL
   } byte_class_t;

   // '-' is always reported as CLS_MINUS; the parser decides whether it is legal.
   function automatic byte_class_t classify(input logic [7:0] b);
      if (b >= CHAR_ZERO && b <= (CHAR_ZERO + 8'd9)) return CLS_DIGIT;
      if (b == CHAR_CR || b == CHAR_LF)               return CLS_TERM;
      if (b == CHAR_SPACE)                            return CLS_SPACE;
      if (b == CHAR_MINUS)                            return CLS_MINUS;
      return CLS_ILLEGAL;
   endfunction

endpackage

// File: rtl/ascii_dec_parser_mac10.sv
// dec_mac10: combinational acc*10 + digit, carry set when the exact result
// does not fit in WIDTH bits.
module dec_mac10 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [3:0]       digit,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH+3:0] ext;
   logic [WIDTH+3:0] sum;

   // (2^W-1)*10 + 9 < 2^(W+4), so four guard bits hold the exact product.
   assign ext    = {4'b0000, acc};
   assign sum    = (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, digit};
   assign result = sum[WIDTH-1:0];
   assign carry  = |sum[WIDTH+3:WIDTH];

endmodule

// File: rtl/ascii_dec_parser.sv
// ASCII decimal number parser for the UART receive path.
// Optional macro ASCII_DEC_SIGNED_EN enables a leading '-' and two's complement range.
//
// state | meaning
// IDLE  | between numbers, waiting for the first digit
// ACCUM | digits of a number being accumulated
// SKIP  | bad character seen, discarding until CR/LF
module ascii_dec_parser
   import ascii_dec_parser_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int MAX_DIGITS = DEFAULT_MAX_DIGITS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             new_rx_data,
   output logic [WIDTH-1:0] value,
   output logic             value_valid,
   output logic             overflow,
   output logic             format_error,
   output logic             busy,
   output logic [3:0]       digit_count
);

`ifdef ASCII_DEC_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] NEG_MAX  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [3:0]       MAX_CNT  = 4'(MAX_DIGITS);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             overflow_q, overflow_d;
   logic             valid_d, ferr_d;

   byte_class_t      cls;
   logic [3:0]       digit;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] mac_result;
   logic             mac_carry;
   logic             mac_over;

   assign cls   = classify(rx_data);
   assign digit = rx_data[3:0];

   // acc holds the magnitude; the legal ceiling depends on the sign typed.
   assign limit = !SIGNED_EN ? ALL_ONES : (neg_q ? NEG_MAX : POS_MAX);

   dec_mac10 #(.WIDTH(WIDTH)) u_mac (
      .acc    (acc_q),
      .digit  (digit),
      .result (mac_result),
      .carry  (mac_carry)
   );

   assign mac_over = mac_carry || (mac_result > limit) || (cnt_q == MAX_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      value_d    = value_q;
      overflow_d = overflow_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      if (new_rx_data) begin
         case (state_q)
            IDLE: begin
               case (cls)
                  CLS_DIGIT: begin
                     acc_d   = WIDTH'(digit);
                     cnt_d   = 4'd1;
                     neg_d   = 1'b0;
                     state_d = ACCUM;
                  end
                  CLS_TERM, CLS_SPACE: begin
                  end
                  CLS_MINUS: begin
                     if (SIGNED_EN) begin
                        acc_d   = '0;
                        cnt_d   = 4'd0;
                        neg_d   = 1'b1;
                        state_d = ACCUM;
                     end else begin
                        ferr_d  = 1'b1;
                        state_d = SKIP;
                     end
                  end
                  default: begin
                     ferr_d  = 1'b1;
                     state_d = SKIP;
                  end
               endcase
            end
            ACCUM: begin
               case (cls)
                  CLS_DIGIT: begin
                     if (mac_over) begin
                        acc_d = limit;
                        ovf_d = 1'b1;
                     end else begin
                        acc_d = mac_result;
                     end
                     if (cnt_q != MAX_CNT) cnt_d = cnt_q + 4'd1;
                  end
                  CLS_TERM: begin
                     // A lone '-' carries no digits and is rejected rather than read as 0.
                     if (SIGNED_EN && cnt_q == 4'd0) begin
                        ferr_d = 1'b1;
                     end else begin
                        valid_d    = 1'b1;
                        value_d    = neg_q ? (ALL_ONES - acc_q + 1'b1) : acc_q;
                        overflow_d = ovf_q;
                     end
                     acc_d   = '0;
                     ovf_d   = 1'b0;
                     cnt_d   = 4'd0;
                     neg_d   = 1'b0;
                     state_d = IDLE;
                  end
                  default: begin
                     ferr_d  = 1'b1;
                     acc_d   = '0;
                     ovf_d   = 1'b0;
                     cnt_d   = 4'd0;
                     neg_d   = 1'b0;
                     state_d = SKIP;
                  end
               endcase
            end
            SKIP: begin
               if (cls == CLS_TERM) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q        <= '0;
         ovf_q        <= 1'b0;
         cnt_q        <= 4'd0;
         neg_q        <= 1'b0;
         value_q      <= '0;
         overflow_q   <= 1'b0;
         value_valid  <= 1'b0;
         format_error <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         ovf_q        <= ovf_d;
         cnt_q        <= cnt_d;
         neg_q        <= neg_d;
         value_q      <= value_d;
         overflow_q   <= overflow_d;
         value_valid  <= valid_d;
         format_error <= ferr_d;
      end
   end

   assign value       = value_q;
   assign overflow    = overflow_q;
   assign busy        = (state_q != IDLE);
   assign digit_count = cnt_q;

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Scoreboard bench for ascii_dec_parser: expected pulses are queued with the
// cycle they must appear in; a monitor queues observed pulses for comparison.
module tb_ascii_dec_parser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        new_rx_data = 1'b0;
   logic [31:0] value;
   logic        value_valid;
   logic        overflow;
   logic        format_error;
   logic        busy;
   logic [3:0]  digit_count;

   typedef struct packed {
      logic        kind;   // 0 = value_valid, 1 = format_error
      logic [31:0] val;
      logic        ovf;
      logic [31:0] cyc;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         obs_q[$];
   logic [31:0] cyc = 32'd0;
   int          n_pass = 0;
   int          n_total = 0;

   ascii_dec_parser dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .new_rx_data  (new_rx_data),
      .value        (value),
      .value_valid  (value_valid),
      .overflow     (overflow),
      .format_error (format_error),
      .busy         (busy),
      .digit_count  (digit_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   always @(negedge clk) begin
      if (value_valid)  obs_q.push_back('{1'b0, value, overflow, cyc});
      if (format_error) obs_q.push_back('{1'b1, 32'd0, 1'b0, cyc});
   end

   // Called at a falling edge; the byte is sampled at the next rising edge.
   task automatic send(input logic [7:0] b);
      rx_data     = b;
      new_rx_data = 1'b1;
      @(negedge clk);
      new_rx_data = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic exp_val(input logic [31:0] v, input logic o);
      exp_q.push_back('{1'b0, v, o, cyc + 32'd1});
   endtask

   task automatic exp_ferr();
      exp_q.push_back('{1'b1, 32'd0, 1'b0, cyc + 32'd1});
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if ({value, value_valid, overflow, format_error, busy, digit_count} !== 41'd0)
         $display("FAIL reset_state: got value=%h vv=%b ovf=%b ferr=%b busy=%b cnt=%0d, required all zero",
                  value, value_valid, overflow, format_error, busy, digit_count);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      obs_q.delete();
   endtask

   task automatic test_decimal();
      ev_t e, o;
      send_str("1234");
      n_total++;
      if (digit_count !== 4'd4 || busy !== 1'b1)
         $display("FAIL decimal_count: got cnt=%0d busy=%b, required cnt=4 busy=1", digit_count, busy);
      else n_pass++;
      exp_val(32'd1234, 1'b0); send(8'h0A);
      send_str("007");
      n_total++;
      if (digit_count !== 4'd3)
         $display("FAIL leading_zero_count: got cnt=%0d, required 3", digit_count);
      else n_pass++;
      exp_val(32'd7, 1'b0); send(8'h0D);
      send(8'h0D); send(8'h0A); send(8'h0A); send(8'h20);
      n_total++;
      if (busy !== 1'b0)
         $display("FAIL blank_lines_busy: got busy=%b, required 0", busy);
      else n_pass++;
      send_str("42"); exp_val(32'd42, 1'b0); send(8'h0A);
      repeat (4) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); n_total++;
         if (obs_q.size() == 0)
            $display("FAIL decimal_event: got none, required kind=%0d value=%h ovf=%b cyc=%0d", e.kind, e.val, e.ovf, e.cyc);
         else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL decimal_event: got kind=%0d value=%h ovf=%b cyc=%0d, required kind=%0d value=%h ovf=%b cyc=%0d",
                                  o.kind, o.val, o.ovf, o.cyc, e.kind, e.val, e.ovf, e.cyc);
            else n_pass++;
         end
      end
      n_total++;
      if (obs_q.size() != 0) begin
         $display("FAIL decimal_extra: got %0d unexpected events, required 0", obs_q.size()); obs_q.delete();
      end else n_pass++;
   endtask

   task automatic test_range();
      ev_t e, o;
      send_str("4294967295");
      n_total++;
      if (digit_count !== 4'd10)
         $display("FAIL max_digits_count: got cnt=%0d, required 10", digit_count);
      else n_pass++;
      exp_val(32'hFFFF_FFFF, 1'b0); send(8'h0D); send(8'h0A);
      send_str("4294967296"); exp_val(32'hFFFF_FFFF, 1'b1); send(8'h0A);
      repeat (3) @(negedge clk);
      n_total++;
      if (overflow !== 1'b1)
         $display("FAIL overflow_hold: got ovf=%b, required 1", overflow);
      else n_pass++;
      send_str("5"); exp_val(32'd5, 1'b0); send(8'h0A);
      send_str("00000000001"); exp_val(32'hFFFF_FFFF, 1'b1); send(8'h0A);
      send_str("99999999999");
      n_total++;
      if (digit_count !== 4'd10)
         $display("FAIL count_saturate: got cnt=%0d, required 10", digit_count);
      else n_pass++;
      exp_val(32'hFFFF_FFFF, 1'b1); send(8'h0A);
      repeat (4) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); n_total++;
         if (obs_q.size() == 0)
            $display("FAIL range_event: got none, required kind=%0d value=%h ovf=%b cyc=%0d", e.kind, e.val, e.ovf, e.cyc);
         else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL range_event: got kind=%0d value=%h ovf=%b cyc=%0d, required kind=%0d value=%h ovf=%b cyc=%0d",
                                  o.kind, o.val, o.ovf, o.cyc, e.kind, e.val, e.ovf, e.cyc);
            else n_pass++;
         end
      end
      n_total++;
      if (obs_q.size() != 0) begin
         $display("FAIL range_extra: got %0d unexpected events, required 0", obs_q.size()); obs_q.delete();
      end else n_pass++;
   endtask

   task automatic test_format_error();
      ev_t e, o;
      send_str("12"); exp_ferr(); send("a"); send_str("34"); send(8'h0A);
      send_str("7"); exp_val(32'd7, 1'b0); send(8'h0A);
      exp_ferr(); send("x"); send_str("9"); send(8'h0D);
      send_str("4"); exp_ferr(); send(8'h20); send_str("2"); send(8'h0A);
      n_total++;
      if (busy !== 1'b0 || digit_count !== 4'd0)
         $display("FAIL skip_exit: got busy=%b cnt=%0d, required busy=0 cnt=0", busy, digit_count);
      else n_pass++;
      send_str("31"); exp_val(32'd31, 1'b0); send(8'h0A);
      repeat (4) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); n_total++;
         if (obs_q.size() == 0)
            $display("FAIL ferr_event: got none, required kind=%0d value=%h ovf=%b cyc=%0d", e.kind, e.val, e.ovf, e.cyc);
         else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL ferr_event: got kind=%0d value=%h ovf=%b cyc=%0d, required kind=%0d value=%h ovf=%b cyc=%0d",
                                  o.kind, o.val, o.ovf, o.cyc, e.kind, e.val, e.ovf, e.cyc);
            else n_pass++;
         end
      end
      n_total++;
      if (obs_q.size() != 0) begin
         $display("FAIL ferr_extra: got %0d unexpected events, required 0", obs_q.size()); obs_q.delete();
      end else n_pass++;
   endtask

   task automatic test_reset_mid();
      ev_t e, o;
      send_str("98");
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({value, value_valid, overflow, format_error, busy, digit_count} !== 41'd0)
         $display("FAIL reset_mid_state: got value=%h vv=%b ovf=%b ferr=%b busy=%b cnt=%0d, required all zero",
                  value, value_valid, overflow, format_error, busy, digit_count);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_str("3"); exp_val(32'd3, 1'b0); send(8'h0A);
      repeat (4) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); n_total++;
         if (obs_q.size() == 0)
            $display("FAIL reset_mid_event: got none, required kind=%0d value=%h ovf=%b cyc=%0d", e.kind, e.val, e.ovf, e.cyc);
         else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL reset_mid_event: got kind=%0d value=%h ovf=%b cyc=%0d, required kind=%0d value=%h ovf=%b cyc=%0d",
                                  o.kind, o.val, o.ovf, o.cyc, e.kind, e.val, e.ovf, e.cyc);
            else n_pass++;
         end
      end
      n_total++;
      if (obs_q.size() != 0) begin
         $display("FAIL reset_mid_extra: got %0d unexpected events, required 0", obs_q.size()); obs_q.delete();
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      ev_t   e, o;
      string s;
      send_str("1"); exp_val(32'd1, 1'b0); send(8'h0A);
      send_str("2"); exp_val(32'd2, 1'b0); send(8'h0A);
      send_str("3"); exp_val(32'd3, 1'b0); send(8'h0D);
      s = "65535";
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      exp_val(32'd65535, 1'b0); send(8'h0A);
      repeat (4) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); n_total++;
         if (obs_q.size() == 0)
            $display("FAIL b2b_event: got none, required kind=%0d value=%h ovf=%b cyc=%0d", e.kind, e.val, e.ovf, e.cyc);
         else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL b2b_event: got kind=%0d value=%h ovf=%b cyc=%0d, required kind=%0d value=%h ovf=%b cyc=%0d",
                                  o.kind, o.val, o.ovf, o.cyc, e.kind, e.val, e.ovf, e.cyc);
            else n_pass++;
         end
      end
      n_total++;
      if (obs_q.size() != 0) begin
         $display("FAIL b2b_extra: got %0d unexpected events, required 0", obs_q.size()); obs_q.delete();
      end else n_pass++;
   endtask

   task automatic test_sign();
      ev_t e, o;
`ifdef ASCII_DEC_SIGNED_EN
      send_str("-2147483648"); exp_val(32'h8000_0000, 1'b0); send(8'h0A);
      send_str("-"); exp_ferr(); send(8'h0A);
      send_str("2147483648"); exp_val(32'h7FFF_FFFF, 1'b1); send(8'h0A);
      send_str("-2147483649"); exp_val(32'h8000_0000, 1'b1); send(8'h0A);
      send_str("-5"); exp_val(32'hFFFF_FFFB, 1'b0); send(8'h0A);
`else
      exp_ferr(); send("-"); send_str("5"); send(8'h0A);
      send_str("6"); exp_val(32'd6, 1'b0); send(8'h0A);
`endif
      repeat (4) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); n_total++;
         if (obs_q.size() == 0)
            $display("FAIL sign_event: got none, required kind=%0d value=%h ovf=%b cyc=%0d", e.kind, e.val, e.ovf, e.cyc);
         else begin
            o = obs_q.pop_front();
            if (o !== e) $display("FAIL sign_event: got kind=%0d value=%h ovf=%b cyc=%0d, required kind=%0d value=%h ovf=%b cyc=%0d",
                                  o.kind, o.val, o.ovf, o.cyc, e.kind, e.val, e.ovf, e.cyc);
            else n_pass++;
         end
      end
      n_total++;
      if (obs_q.size() != 0) begin
         $display("FAIL sign_extra: got %0d unexpected events, required 0", obs_q.size()); obs_q.delete();
      end else n_pass++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_decimal();
      test_range();
      test_format_error();
      test_reset_mid();
      test_back_to_back();
      test_sign();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
